dff_reg: RTL and testbench

Parameterized edge-triggered storage register: captures `d` on every rising edge of `clk` and presents it on `q`, with an asynchronous active-high clear to a programmable reset value. The default configuration (1 bit, 1 stage) is the plain D flip-flop used as the basic storage primitive throughout the design. Wider or deeper configurations serve as data registers and fixed-latency delay lines.

---
 rtl/dff_stage.sv | 21 ++
 rtl/dff_reg.sv | 41 ++++
 tb/tb_dff_reg.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dff_stage.sv
`timescale 1ns/1ps
// Single WIDTH-bit storage flop with asynchronous active-high clear to RST_VAL.
module dff_stage #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_reg.sv
`timescale 1ns/1ps
// Parameterized storage register / fixed-latency delay line built from
// STAGES back-to-back dff_stage flops; q comes straight off the last stage.
module dff_reg #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned STAGES = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1) begin : g_bad_width
    $error("dff_reg: WIDTH must be at least 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("dff_reg: STAGES must be at least 1");
  end

  // chain[0] is the input, chain[k+1] is the output of stage k.
  logic [WIDTH-1:0] chain [0:STAGES];

  assign chain[0] = d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    dff_stage #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .d  (chain[k]),
      .q  (chain[k+1])
    );
  end

  assign q = chain[STAGES];

endmodule

// File: tb/tb_dff_reg.sv
`timescale 1ns/1ps
// Directed bench for dff_reg across several configurations sharing one clock
// and one reset: default flop, 8x3 delay line, A5-reset register, latency set.
module tb_dff_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_def;
  logic       q_def;
  logic [7:0] d_w8s3;
  logic [7:0] q_w8s3;
  logic [7:0] d_a5;
  logic [7:0] q_a5;
  logic       d_lat;
  logic       q_s1;
  logic       q_s2;
  logic       q_s4;

  int n_checks = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  dff_reg u_def (.clk(clk), .rst(rst), .d(d_def), .q(q_def));

  dff_reg #(.WIDTH(8), .STAGES(3)) u_w8s3 (
    .clk(clk), .rst(rst), .d(d_w8s3), .q(q_w8s3)
  );

  dff_reg #(.WIDTH(8), .STAGES(2), .RST_VAL(8'hA5)) u_a5 (
    .clk(clk), .rst(rst), .d(d_a5), .q(q_a5)
  );

  dff_reg #(.WIDTH(1), .STAGES(1)) u_s1 (.clk(clk), .rst(rst), .d(d_lat), .q(q_s1));
  dff_reg #(.WIDTH(1), .STAGES(2)) u_s2 (.clk(clk), .rst(rst), .d(d_lat), .q(q_s2));
  dff_reg #(.WIDTH(1), .STAGES(4)) u_s4 (.clk(clk), .rst(rst), .d(d_lat), .q(q_s4));

  task automatic test_reset();
    #1 rst = 1'b1;
    #0.01;
    n_checks++;
    if (q_def !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_def: got %b expected 0", q_def);
    end
    n_checks++;
    if (q_w8s3 !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_w8s3: got %h expected 00", q_w8s3);
    end
    n_checks++;
    if (q_a5 !== 8'hA5) begin
      n_fail++;
      $display("FAIL async_reset_a5: got %h expected a5", q_a5);
    end
    // clock edges while in reset must not capture
    d_def = 1'b1;
    d_w8s3 = 8'hFF;
    d_a5 = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q_def !== 1'b0 || q_w8s3 !== 8'h00 || q_a5 !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_holds: got def=%b w8s3=%h a5=%h expected 0/00/a5",
               q_def, q_w8s3, q_a5);
    end
    @(negedge clk);
    d_w8s3 = 8'h00;
    d_a5 = 8'h00;
    rst = 1'b0;
  endtask

  task automatic test_random_capture();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      d_def = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      n_checks++;
      if (q_def !== d_def) begin
        n_fail++;
        $display("FAIL random_capture[%0d]: got %b expected %b", i, q_def, d_def);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] seq_in [3];
    logic [7:0] seq_exp [4];
    seq_in = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_w8s3 = seq_in[i];
      @(posedge clk);
    end
    #1;
    n_checks++;
    if (q_w8s3 !== 8'h11) begin
      n_fail++;
      $display("FAIL midstream_fill: got %h expected 11", q_w8s3);
    end
    @(negedge clk);
    d_w8s3 = 8'h44;
    rst = 1'b1;
    #1;
    n_checks++;
    if (q_w8s3 !== 8'h00) begin
      n_fail++;
      $display("FAIL midstream_async_clear: got %h expected 00", q_w8s3);
    end
    #2 rst = 1'b0;
    seq_in = '{8'h55, 8'h66, 8'h77};
    seq_exp = '{8'h00, 8'h00, 8'h44, 8'h55};
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (q_w8s3 !== seq_exp[e]) begin
        n_fail++;
        $display("FAIL midstream_release_edge%0d: got %h expected %h",
                 e + 1, q_w8s3, seq_exp[e]);
      end
      if (e < 3) begin
        @(negedge clk);
        d_w8s3 = seq_in[e];
      end
    end
  endtask

  task automatic test_coincident_edges();
    @(negedge clk);
    rst = 1'b1;
    d_def = 1'b1;
    // release lands on the edge itself: flop must still see reset
    @(posedge clk);
    rst <= 1'b0;
    #1;
    n_checks++;
    if (q_def !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_release_edge: got %b expected 0", q_def);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (q_def !== 1'b1) begin
      n_fail++;
      $display("FAIL coincident_release_next: got %b expected 1", q_def);
    end
    // assertion landing on an edge: reset wins
    @(posedge clk);
    rst <= 1'b1;
    #1;
    n_checks++;
    if (q_def !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_assert: got %b expected 0", q_def);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nonzero_rst_val();
    logic [7:0] seq_in [4];
    logic [7:0] seq_exp [4];
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (q_a5 !== 8'hA5) begin
      n_fail++;
      $display("FAIL a5_in_reset: got %h expected a5", q_a5);
    end
    @(negedge clk);
    rst = 1'b0;
    seq_in = '{8'h01, 8'h02, 8'h03, 8'h04};
    seq_exp = '{8'hA5, 8'h01, 8'h02, 8'h03};
    for (int e = 0; e < 4; e++) begin
      d_a5 = seq_in[e];
      @(posedge clk);
      #1;
      n_checks++;
      if (q_a5 !== seq_exp[e]) begin
        n_fail++;
        $display("FAIL a5_track_edge%0d: got %h expected %h", e + 1, q_a5, seq_exp[e]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_latency_sweep();
    logic [2:0] exp_v;
    logic [2:0] got_v;
    d_lat = 1'b0;
    repeat (6) @(negedge clk);
    d_lat = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      exp_v = {e == 4, e == 2, e == 1};
      got_v = {q_s4, q_s2, q_s1};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL latency_edge%0d: got s4/s2/s1=%b expected %b", e, got_v, exp_v);
      end
      @(negedge clk);
      d_lat = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    d_def = 1'b0;
    d_w8s3 = 8'h00;
    d_a5 = 8'h00;
    d_lat = 1'b0;
    test_reset();
    test_random_capture();
    test_midstream_reset();
    test_coincident_edges();
    test_nonzero_rst_val();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
